// File: rtl/i2s_out_tdm_if.sv
// Frame handshake between the filter output and the I2S/TDM transmitter.
interface i2s_out_tdm_if #(
    parameter int unsigned FRAME_W = 32
);
    logic               filt_rts;
    logic               filt_rtr;
    logic [FRAME_W-1:0] filt_data;

    modport master (output filt_rts, output filt_data, input filt_rtr);
    modport slave  (input filt_rts, input filt_data, output filt_rtr);
endinterface

// File: rtl/i2s_out_tdm.sv
// I2S / left-justified / TDM serial transmitter with a frame FIFO and sticky
// underrun/overrun status. All ws/sd changes happen on sck_transition pulses.
module i2s_out_tdm #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned FIFO_AW  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sck_transition,
    input  logic               rf_i2so_en,
    input  logic               rf_i2so_mode,
    i2s_out_tdm_if.slave       filt,
    output logic               i2so_ws,
    output logic               i2so_sd,
    output logic [FIFO_AW:0]   ro_fifo_level,
    output logic               ro_fifo_underrun,
    input  logic               trig_fifo_underrun,
    output logic               ro_fifo_overrun,
    input  logic               trig_fifo_overrun
);
    localparam int unsigned FRAME_W = SAMPLE_W * NUM_CH;
    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned CNT_W   = FIFO_AW + 1;
    localparam int unsigned BIT_W   = $clog2(SAMPLE_W);
    localparam int unsigned SLOT_W  = $clog2(NUM_CH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state;
    logic [FRAME_W-1:0] mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [BIT_W-1:0]   bit_cnt;
    logic [SLOT_W-1:0]  slot;
    logic [FRAME_W-1:0] sreg;
    logic               mode_q;
    logic               prev_bit;

    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               starve;
    logic               last_bit_pos;
    logic               last_pos;
    logic               load;
    logic               stop;
    logic               step;
    logic [FRAME_W-1:0] load_word;
    logic [BIT_W-1:0]   bit_nxt;
    logic [SLOT_W-1:0]  slot_nxt;

    // Position decode, frame-boundary events and FIFO handshake.
    always_comb begin
        full         = (count == CNT_W'(DEPTH));
        empty        = (count == '0);
        last_bit_pos = (bit_cnt == BIT_W'(SAMPLE_W - 1));
        last_pos     = last_bit_pos && (slot == SLOT_W'(NUM_CH - 1));
        load         = sck_transition && rf_i2so_en &&
                       ((state == IDLE) || ((state == RUN) && last_pos));
        stop         = sck_transition && !rf_i2so_en && (state == RUN) && last_pos;
        step         = sck_transition && (state == RUN) && !last_pos;
        push         = filt.filt_rts && !full;
        pop          = load && !empty;
        starve       = load && empty;
        load_word    = empty ? '0 : mem[rd_ptr];
        bit_nxt      = last_bit_pos ? '0 : bit_cnt + 1'b1;
        slot_nxt     = last_bit_pos ? slot + 1'b1 : slot;
    end

    assign filt.filt_rtr = ~full;
    assign ro_fifo_level = count;

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= filt.filt_data;
        end
    end

    // FIFO pointers, occupancy and sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            ro_fifo_underrun <= 1'b0;
            ro_fifo_overrun  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end

            if (starve) begin
                ro_fifo_underrun <= 1'b1;
            end else if (trig_fifo_underrun) begin
                ro_fifo_underrun <= 1'b0;
            end

            if (filt.filt_rts && full) begin
                ro_fifo_overrun <= 1'b1;
            end else if (trig_fifo_overrun) begin
                ro_fifo_overrun <= 1'b0;
            end
        end
    end

    // Serialiser FSM: prev_bit is the left-justified bit of the previous
    // position, which is what I2S mode puts on sd one bit time later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            slot     <= '0;
            sreg     <= '0;
            mode_q   <= 1'b0;
            prev_bit <= 1'b0;
            i2so_ws  <= 1'b0;
            i2so_sd  <= 1'b0;
        end else begin
            if (load) begin
                state    <= RUN;
                bit_cnt  <= '0;
                slot     <= '0;
                sreg     <= {load_word[FRAME_W-2:0], 1'b0};
                mode_q   <= rf_i2so_mode;
                prev_bit <= load_word[FRAME_W-1];
                i2so_sd  <= rf_i2so_mode ? load_word[FRAME_W-1] : prev_bit;
                i2so_ws  <= (NUM_CH > 2);
            end else if (stop) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                slot     <= '0;
                sreg     <= '0;
                prev_bit <= 1'b0;
                i2so_sd  <= 1'b0;
                i2so_ws  <= 1'b0;
            end else if (step) begin
                bit_cnt  <= bit_nxt;
                slot     <= slot_nxt;
                sreg     <= {sreg[FRAME_W-2:0], 1'b0};
                prev_bit <= sreg[FRAME_W-1];
                i2so_sd  <= mode_q ? sreg[FRAME_W-1] : prev_bit;
                i2so_ws  <= (NUM_CH == 2) ? slot_nxt[0] : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_out_tdm.sv
// Scoreboard bench: a stereo 16-bit and a 4-channel 8-bit transmitter share one
// stimulus stream (both 32-bit frames) and are checked against a frame-level model.
`timescale 1ns/1ps
module tb_i2s_out_tdm;
    localparam int FW    = 32;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic       ws_a;
        logic       ws_b;
        logic       sd;
        logic       rtr;
        logic       uf;
        logic       ovf;
        logic [3:0] lvl;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, sck, en, mode, trig_u, trig_o, rts;
    logic [FW-1:0] din;
    logic          ws_a, sd_a, uf_a, of_a, ws_b, sd_b, uf_b, of_b;
    logic [3:0]    lvl_a, lvl_b;

    int n_vec = 0;
    int n_bad = 0;
    int n_cyc = 0;

    exp_t          expq[$];
    logic [FW-1:0] mq[$];
    bit            m_run, m_mode, m_prev, m_uf, m_of, m_wsa, m_wsb, m_sd;
    int            m_pos;
    logic [FW-1:0] m_frame;

    i2s_out_tdm_if #(.FRAME_W(FW)) bus_a ();
    i2s_out_tdm_if #(.FRAME_W(FW)) bus_b ();
    assign bus_a.filt_rts  = rts;
    assign bus_a.filt_data = din;
    assign bus_b.filt_rts  = rts;
    assign bus_b.filt_data = din;

    i2s_out_tdm #(.SAMPLE_W(16), .NUM_CH(2), .FIFO_AW(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .sck_transition(sck), .rf_i2so_en(en),
        .rf_i2so_mode(mode), .filt(bus_a.slave), .i2so_ws(ws_a), .i2so_sd(sd_a),
        .ro_fifo_level(lvl_a), .ro_fifo_underrun(uf_a), .trig_fifo_underrun(trig_u),
        .ro_fifo_overrun(of_a), .trig_fifo_overrun(trig_o));

    i2s_out_tdm #(.SAMPLE_W(8), .NUM_CH(4), .FIFO_AW(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .sck_transition(sck), .rf_i2so_en(en),
        .rf_i2so_mode(mode), .filt(bus_b.slave), .i2so_ws(ws_b), .i2so_sd(sd_b),
        .ro_fifo_level(lvl_b), .ro_fifo_underrun(uf_b), .trig_fifo_underrun(trig_u),
        .ro_fifo_overrun(of_b), .trig_fifo_overrun(trig_o));

    always #5 clk = ~clk;

    // Reference model: predicts the state visible after the coming clock edge.
    function automatic void model_edge();
        bit   full, starve, ser, lj;
        exp_t e;
        if (!rst_n) begin
            mq.delete();
            m_run = 0; m_pos = 0; m_frame = '0; m_mode = 0; m_prev = 0;
            m_uf = 0; m_of = 0; m_wsa = 0; m_wsb = 0; m_sd = 0;
        end else begin
            full   = (mq.size() == DEPTH);
            starve = 0;
            ser    = 0;
            if (sck) begin
                if (!m_run || m_pos == FW - 1) begin
                    if (en) begin
                        m_run  = 1;
                        m_pos  = 0;
                        ser    = 1;
                        m_mode = mode;
                        if (mq.size() == 0) begin
                            m_frame = '0;
                            starve  = 1;
                        end else begin
                            m_frame = mq.pop_front();
                        end
                    end else if (m_run) begin
                        m_run = 0; m_prev = 0; m_sd = 0; m_wsa = 0; m_wsb = 0;
                    end
                end else begin
                    m_pos++;
                    ser = 1;
                end
            end
            if (ser) begin
                lj     = m_frame[FW - 1 - m_pos];
                m_sd   = m_mode ? lj : m_prev;
                m_prev = lj;
                m_wsa  = ((m_pos / 16) % 2) == 1;
                m_wsb  = (m_pos == 0);
            end
            if (rts && !full) mq.push_back(din);
            if (starve) m_uf = 1; else if (trig_u) m_uf = 0;
            if (rts && full) m_of = 1; else if (trig_o) m_of = 0;
        end
        e.ws_a = m_wsa;
        e.ws_b = m_wsb;
        e.sd   = m_sd;
        e.rtr  = (mq.size() != DEPTH);
        e.uf   = m_uf;
        e.ovf  = m_of;
        e.lvl  = 4'(mq.size());
        expq.push_back(e);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, n_cyc, act, exp);
        end
    endfunction

    // Monitor: one expected record per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            n_cyc++;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                chk("ws_a", 32'(ws_a), 32'(e.ws_a));
                chk("ws_b", 32'(ws_b), 32'(e.ws_b));
                chk("sd_a", 32'(sd_a), 32'(e.sd));
                chk("sd_b", 32'(sd_b), 32'(e.sd));
                chk("rtr_a", 32'(bus_a.filt_rtr), 32'(e.rtr));
                chk("rtr_b", 32'(bus_b.filt_rtr), 32'(e.rtr));
                chk("underrun_a", 32'(uf_a), 32'(e.uf));
                chk("underrun_b", 32'(uf_b), 32'(e.uf));
                chk("overrun_a", 32'(of_a), 32'(e.ovf));
                chk("overrun_b", 32'(of_b), 32'(e.ovf));
                chk("level_a", 32'(lvl_a), 32'(e.lvl));
                chk("level_b", 32'(lvl_b), 32'(e.lvl));
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", n_cyc);
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        model_edge();
        @(negedge clk);
        sck    = 1'b0;
        trig_u = 1'b0;
        trig_o = 1'b0;
    endtask

    task automatic run_bits(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            sck = 1'b1;
            cyc();
            for (int g = 0; g < gap; g++) cyc();
        end
    endtask

    task automatic push_frame(input logic [FW-1:0] d);
        rts = 1'b1;
        din = d;
        cyc();
        rts = 1'b0;
    endtask

    task automatic to_last_pos();
        for (int i = 0; i < 40 && !(m_run && m_pos == FW - 1); i++) run_bits(1, 1);
    endtask

    initial begin
        rst_n = 0; sck = 0; en = 0; mode = 0; trig_u = 0; trig_o = 0; rts = 0; din = '0;
        @(negedge clk);
        cyc();
        cyc();
        rst_n = 1;
        run_bits(4, 1);

        // I2S frame, then a starved frame
        push_frame(32'hA5A5_0F0F);
        en = 1;
        run_bits(34, 1);
        trig_u = 1;
        cyc();

        // Left-justified frames; mode switch lands at the next boundary
        mode = 1;
        push_frame(32'hA5A5_0F0F);
        push_frame(32'h1122_3344);
        run_bits(31 + 64, 1);

        // Clear arriving on the same clock as a starved load
        to_last_pos();
        sck = 1; trig_u = 1;
        cyc();
        run_bits(3, 1);

        // Disable mid-frame at bit 5 of a TDM frame, frame completes
        push_frame(32'h1122_3344);
        to_last_pos();
        run_bits(6, 1);
        en = 0;
        run_bits(36, 1);

        // Fill the FIFO while disabled, overrun held while rts stays high
        rts = 1;
        for (int i = 0; i < 11; i++) begin
            din = $urandom;
            cyc();
        end
        trig_o = 1;
        cyc();
        rts = 0;
        cyc();
        trig_o = 1;
        cyc();
        cyc();

        // Async reset in the middle of a frame
        en = 1; mode = 0;
        run_bits(10, 0);
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            sck    = ($urandom_range(0, 1) == 1);
            rts    = ($urandom_range(0, (i < 1500) ? 40 : 90) == 0);
            din    = $urandom;
            trig_u = ($urandom_range(0, 30) == 0);
            trig_o = ($urandom_range(0, 30) == 0);
            if ($urandom_range(0, 250) == 0) en = ~en;
            if ($urandom_range(0, 120) == 0) mode = ~mode;
            if ($urandom_range(0, 1500) == 0) rst_n = 0;
            cyc();
            rts   = 0;
            rst_n = 1;
        end
        cyc();
        @(negedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
